uart_transmit_controller: RTL

//  Transmit half of the UART core. Accepts 8-bit bytes from the host side into a one-byte holding register.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_transmit_controller.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states and bit-framing constants.
// The receive controller uses UART_TICKS_PER_BIT and UART_DATA_BITS as well.
package uart_pkg;

    localparam int UART_TICKS_PER_BIT = 16;
    localparam int UART_DATA_BITS     = 8;

    typedef enum logic [2:0] {
        S_TXC_IDLE   = 3'd0,
        S_TXC_START  = 3'd1,
        S_TXC_DATA   = 3'd2,
        S_TXC_PARITY = 3'd3,
        S_TXC_STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_transmit_controller.sv
// UART transmitter: one-byte holding register feeding an 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert a parity bit between data and stop.
module uart_transmit_controller
    import uart_pkg::*;
#(
    parameter int C_BAUDRATE    = 115_200,
    parameter int C_SYSTEM_FREQ = 50_000_000,
    parameter int C_PARITY_ODD  = 0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Enable,
    input  logic       Load_data,
    input  logic [7:0] TX_data,
    input  logic       baud_tick,
    output logic       Empty,
    output logic       Busy,
    output logic       Overrun,
    output logic       UART_TX_O
);

    localparam logic [3:0] TICK_LAST = 4'(UART_TICKS_PER_BIT - 1);
    localparam logic [2:0] BIT_LAST  = 3'(UART_DATA_BITS - 1);

    // Reject configurations the 16x baud generator cannot produce.
    if (C_BAUDRATE <= 0 ||
        C_SYSTEM_FREQ < C_BAUDRATE * UART_TICKS_PER_BIT ||
        C_PARITY_ODD < 0 || C_PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_transmit_controller: bad parameters");
    end

    tx_state_t  state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic [7:0] shift_q, shift_d;
    logic       empty_q, empty_d;
    logic [3:0] tick_q, tick_d;
    logic [2:0] bit_q, bit_d;
    logic       tx_q, tx_d;
    logic       ovr_q, ovr_d;
`ifdef UART_TX_PARITY_EN
    localparam logic PAR_ODD = (C_PARITY_ODD != 0);
    logic       par_q, par_d;
`endif

    logic end_bit;
    logic start_frame;
    logic accept;

    assign end_bit = (state_q != S_TXC_IDLE) && baud_tick &&
                     (tick_q == TICK_LAST);

    // A frame starts from idle, or directly out of a finishing stop bit.
    assign start_frame = Enable && !empty_q &&
                         ((state_q == S_TXC_IDLE) ||
                          (state_q == S_TXC_STOP && end_bit));

    assign accept = Load_data && (empty_q || start_frame);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        shift_d = shift_q;
        empty_d = empty_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        ovr_d   = Load_data && !accept;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif

        if (state_q != S_TXC_IDLE && baud_tick) begin
            tick_d = tick_q + 4'd1;
        end

        unique case (state_q)
            S_TXC_IDLE: begin
                tx_d = 1'b1;
            end
            S_TXC_START: begin
                if (end_bit) begin
                    state_d = S_TXC_DATA;
                    tx_d    = shift_q[0];
                end
            end
            S_TXC_DATA: begin
                if (end_bit) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    tx_d    = shift_q[1];
                    if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_TXC_PARITY;
                        tx_d    = par_q;
`else
                        state_d = S_TXC_STOP;
                        tx_d    = 1'b1;
`endif
                    end
                end
            end
            S_TXC_PARITY: begin
                if (end_bit) begin
                    state_d = S_TXC_STOP;
                    tx_d    = 1'b1;
                end
            end
            S_TXC_STOP: begin
                if (end_bit) begin
                    state_d = S_TXC_IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = S_TXC_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (start_frame) begin
            state_d = S_TXC_START;
            shift_d = hold_q;
            empty_d = 1'b1;
            tick_d  = 4'd0;
            bit_d   = 3'd0;
            tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_d   = (^hold_q) ^ PAR_ODD;
`endif
        end

        if (accept) begin
            hold_d  = TX_data;
            empty_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_TXC_IDLE;
            hold_q  <= 8'h00;
            shift_q <= 8'h00;
            empty_q <= 1'b1;
            tick_q  <= 4'd0;
            bit_q   <= 3'd0;
            tx_q    <= 1'b1;
            ovr_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            shift_q <= shift_d;
            empty_q <= empty_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            ovr_q   <= ovr_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign Empty     = empty_q;
    assign Busy      = (state_q != S_TXC_IDLE);
    assign Overrun   = ovr_q;
    assign UART_TX_O = tx_q;

endmodule
